latch_bank_wr_ctrl: RTL and testbench

- Write-side sequencer for a bank of NLAT enable-transparent latches, each NLAT word being W bits wide, with a shared active-low preset.
- Turns a valid/ready request stream into the pin-level signals the latches consume:
  - shared data bus D;
  - one-hot enable E;
  - shared preset SETN.
- Guarantees setup, enable-pulse, hold and preset-recovery windows in CLK cycles.
- Sits between a register-programming master and the latch array.

---
 rtl/latch_bank_wr_ctrl_if.sv | 30 +++
 rtl/latch_bank_wr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/latch_bank_wr_ctrl_if.sv
// Request and latch-pin bundle for latch_bank_wr_ctrl.
//   master : drives REQ_VALID/REQ_OP/REQ_ADDR/REQ_DATA and observes everything else
//   slave  : the controller; accepts requests and drives D, E, SETN, BUSY, DONE, ERR
interface latch_bank_wr_ctrl_if #(
  parameter int NLAT = 8,
  parameter int W    = 8,
  parameter int AW   = 3
);
  logic            REQ_VALID;
  logic            REQ_READY;
  logic            REQ_OP;
  logic [AW-1:0]   REQ_ADDR;
  logic [W-1:0]    REQ_DATA;
  logic [W-1:0]    D;
  logic [NLAT-1:0] E;
  logic            SETN;
  logic            BUSY;
  logic            DONE;
  logic            ERR;

  modport master (
    output REQ_VALID, REQ_OP, REQ_ADDR, REQ_DATA,
    input  REQ_READY, D, E, SETN, BUSY, DONE, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_ADDR, REQ_DATA,
    output REQ_READY, D, E, SETN, BUSY, DONE, ERR
  );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// Write-side sequencer for a bank of NLAT enable-transparent latches.
// Converts a valid/ready request stream into D / one-hot E / active-low SETN
// with guaranteed setup, enable-pulse, hold and preset-recovery windows.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   bus  - slave side of latch_bank_wr_ctrl_if (request handshake + latch pins,
//          BUSY, DONE and ERR status pulses). All bus outputs are registered.
module latch_bank_wr_ctrl #(
  parameter int NLAT       = 8,
  parameter int W          = 8,
  parameter int AW         = 3,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int PRESET_CYC = 2
) (
  input logic                 CLK,
  input logic                 RST,
  latch_bank_wr_ctrl_if.slave bus
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CW = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, PRESET_CYC) + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, PRESET, RECOVER} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic            oor_q, oor_n;
  logic [W-1:0]    d_q, d_n;
  logic [NLAT-1:0] e_q, e_n;
  logic            setn_q, setn_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            ready_q;
  logic            busy_q;
  logic            accept;

  // REQ_READY is only ever high in IDLE, so the handshake alone qualifies acceptance.
  assign accept = bus.REQ_VALID && ready_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      d_q     <= '0;
      e_q     <= '0;
      setn_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      oor_q   <= oor_n;
      d_q     <= d_n;
      e_q     <= e_n;
      setn_q  <= setn_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
    end
  end

  // Computes the next state together with the next value of every registered
  // output, so each pin reflects the state it is entering at the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    oor_n   = oor_q;
    d_n     = d_q;
    e_n     = '0;
    setn_n  = 1'b1;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.REQ_OP) begin
            state_n = PRESET;
            cnt_n   = CW'(PRESET_CYC - 1);
            setn_n  = 1'b0;
          end else begin
            state_n = SETUP;
            cnt_n   = CW'(SETUP_CYC - 1);
            d_n     = bus.REQ_DATA;
            addr_n  = bus.REQ_ADDR;
            oor_n   = (32'(bus.REQ_ADDR) >= 32'(NLAT));
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = CW'(PULSE_CYC - 1);
          e_n     = oor_q ? '0 : (NLAT'(1) << addr_q);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_n = cnt - CW'(1);
          e_n   = e_q;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = oor_q;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      PRESET: begin
        if (cnt == '0) begin
          state_n = RECOVER;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt - CW'(1);
          setn_n = 1'b0;
        end
      end
      RECOVER: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.REQ_READY = ready_q;
  assign bus.D         = d_q;
  assign bus.E         = e_q;
  assign bus.SETN      = setn_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Self-checking bench for latch_bank_wr_ctrl (NLAT=8, AW=4 so out-of-range
// addresses are reachable). Expected pin values come from a phase-based model:
// each accepted request records its start edge and every output is derived
// from the elapsed cycle count against the configured window lengths.
module tb_latch_bank_wr_ctrl;
  localparam int NLAT = 8;
  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int H    = 1;
  localparam int PR   = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  latch_bank_wr_ctrl_if #(.NLAT(NLAT), .W(W), .AW(AW)) bus ();

  latch_bank_wr_ctrl #(
    .NLAT(NLAT), .W(W), .AW(AW),
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .PRESET_CYC(PR)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // reference model state
  bit         m_seen     = 0;
  bit         m_rst_last = 0;
  bit         m_active   = 0;
  bit         m_op       = 0;
  int         m_addr     = 0;
  int         m_t0       = 0;
  bit         m_ready    = 0;
  logic [7:0] m_d        = '0;
  logic [7:0] prev_d     = '0;
  int         done_edges[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  task automatic compare();
    int   ph, total;
    bit   busy, done, err, setn;
    logic [7:0] e;
    ph    = edge_n - m_t0 + 1;
    total = m_op ? PR + 1 : S + P + H;
    busy  = m_active && ph <= total;
    done  = m_active && ph == total + 1;
    err   = done && !m_op && m_addr >= NLAT;
    setn  = !(m_active && m_op && ph <= PR);
    e     = (m_active && !m_op && ph > S && ph <= S + P && m_addr < NLAT) ? 8'(1 << m_addr) : 8'h00;
    m_ready = !m_rst_last && !busy;
    chk("E", bus.E, e);
    chk("SETN", bus.SETN, setn);
    chk("D", bus.D, m_d);
    chk("BUSY", bus.BUSY, busy);
    chk("DONE", bus.DONE, done);
    chk("ERR", bus.ERR, err);
    chk("REQ_READY", bus.REQ_READY, m_ready);
    if (bus.E != '0) chk("d_stable_under_e", bus.D, prev_d);
    if (bus.E != '0) chk("e_setn_exclusive", bus.SETN, 1'b1);
    prev_d = bus.D;
    if (done) done_edges.push_back(edge_n);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit rst, input bit valid, input bit op, input int addr,
                      input logic [7:0] data);
    RST           = rst;
    bus.REQ_VALID = valid;
    bus.REQ_OP    = op;
    bus.REQ_ADDR  = AW'(addr);
    bus.REQ_DATA  = data;
    @(posedge CLK);
    edge_n++;
    if (rst) begin
      m_seen     = 1;
      m_rst_last = 1;
      m_active   = 0;
      m_d        = '0;
    end else begin
      m_rst_last = 0;
      if (m_seen && m_ready && valid) begin
        m_active = 1;
        m_t0     = edge_n;
        m_op     = op;
        m_addr   = addr;
        if (!op) m_d = data;
      end
    end
    @(negedge CLK);
    if (m_seen) compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  // Hold the request valid until the model says it was accepted (bounded).
  task automatic send(input bit op, input int addr, input logic [7:0] data);
    bit was_ready;
    int n;
    n = 0;
    do begin
      was_ready = m_ready;
      step(0, 1, op, addr, data);
      n++;
    end while (!was_ready && n < 50);
    if (!was_ready) chk("accept_timeout", bus.REQ_READY, 1'b1);
  endtask

  initial begin
    // reset with a pending request
    for (int i = 0; i < 3; i++) step(1, 1, 0, 5, 8'hA5);
    idle(2);

    // single write, addr 5, data A5
    send(0, 5, 8'hA5);
    idle(6);

    // back-to-back writes with the second held valid
    done_edges.delete();
    send(0, 3, 8'h11);
    send(0, 3, 8'h22);
    idle(6);
    chk("b2b_done_count", done_edges.size(), 2);
    if (done_edges.size() == 2) chk("b2b_done_spacing", done_edges[1] - done_edges[0], 5);

    // preset
    send(1, 0, 8'hFF);
    idle(5);

    // out-of-range address
    done_edges.delete();
    send(0, 9, 8'h3C);
    idle(6);
    chk("oor_done_count", done_edges.size(), 1);

    // reset during the first PULSE cycle of a write to addr 0
    done_edges.delete();
    send(0, 0, 8'h5A);
    step(0, 0, 0, 0, 8'h00);
    chk("abort_in_pulse", bus.E, 8'h01);
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    chk("abort_no_done", done_edges.size(), 0);
    send(0, 2, 8'h77);
    idle(6);
    chk("after_abort_done", done_edges.size(), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 15)), 8'($urandom));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
